// File: rtl/keypad_time_entry_pkg.sv
// rtl/keypad_time_entry_pkg.sv - shared types and constants for keypad time entry
package keypad_time_entry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam int          DIGIT_W      = 4;
  localparam logic [3:0]  MAX_SEC_TENS = 4'd5;
  localparam logic [3:0]  MAX_BCD      = 4'd9;

endpackage

// File: rtl/bcd_shift4.sv
// rtl/bcd_shift4.sv - four-stage BCD digit shift register, new digit enters at d0
module bcd_shift4
  import keypad_time_entry_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] d3,
  output logic [DIGIT_W-1:0] d2,
  output logic [DIGIT_W-1:0] d1,
  output logic [DIGIT_W-1:0] d0
);

  logic [4*DIGIT_W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clr) begin
      sr_d = '0;
    end else if (shift_en) begin
      sr_d = {sr_q[3*DIGIT_W-1:0], din};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign d3 = sr_q[4*DIGIT_W-1:3*DIGIT_W];
  assign d2 = sr_q[3*DIGIT_W-1:2*DIGIT_W];
  assign d1 = sr_q[2*DIGIT_W-1:DIGIT_W];
  assign d0 = sr_q[DIGIT_W-1:0];

endmodule

// File: rtl/keypad_time_entry.sv
// rtl/keypad_time_entry.sv - assembles keypad digits into an MM:SS cook time and hands it to the timer
module keypad_time_entry
  import keypad_time_entry_pkg::*;
#(
  parameter int MAX_DIGITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  input  logic       enablen,
  input  logic       start,
  input  logic       clear,
  input  logic       done,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] digit_count,
  output logic       locked,
  output logic       load,
  output logic       err
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  state_e     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic       locked_q, locked_d;
  logic       load_q, load_d;
  logic       err_q, err_d;
  logic       shift_en, clr;
  logic       time_zero, time_ok;

  bcd_shift4 u_digits (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .shift_en (shift_en),
    .din      (digit),
    .d3       (min_tens),
    .d2       (min_ones),
    .d1       (sec_tens),
    .d0       (sec_ones)
  );

  assign time_zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                     (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign time_ok   = !time_zero && (sec_tens <= MAX_SEC_TENS);

  // Event priority below the reset: clear, done (LOCKED only), start, digit.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    locked_d = locked_q;
    load_d   = 1'b0;
    err_d    = 1'b0;
    shift_en = 1'b0;
    clr      = 1'b0;
    if (clear || (done && state_q == ST_LOCKED)) begin
      clr      = 1'b1;
      state_d  = ST_IDLE;
      count_d  = 3'd0;
      locked_d = 1'b0;
    end else if (start && state_q != ST_LOCKED) begin
      if (time_ok) begin
        state_d  = ST_LOCKED;
        locked_d = 1'b1;
        load_d   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (digit_valid && !enablen && digit <= MAX_BCD &&
                 state_q != ST_LOCKED && count_q < MAX_CNT) begin
      shift_en = 1'b1;
      count_d  = count_q + 3'd1;
      state_d  = ST_ENTRY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= 3'd0;
      locked_q <= 1'b0;
      load_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      locked_q <= locked_d;
      load_q   <= load_d;
      err_q    <= err_d;
    end
  end

  assign digit_count = count_q;
  assign locked      = locked_q;
  assign load        = load_q;
  assign err         = err_q;

endmodule

// File: tb/tb_keypad_time_entry.sv
// tb/tb_keypad_time_entry.sv - randomized bench for keypad_time_entry against a decimal-arithmetic model
module tb_keypad_time_entry;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit = 4'd0;
  logic       digit_valid = 1'b0;
  logic       enablen = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic       done = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [2:0] digit_count;
  logic       locked, load, err;

  int n_vec  = 0;
  int n_fail = 0;

  // Model: the entered time as a plain decimal number 0..9999.
  int m_time = 0;
  int m_cnt  = 0;
  bit m_lock = 0;
  bit m_load = 0;
  bit m_err  = 0;

  keypad_time_entry #(.MAX_DIGITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .digit       (digit),
    .digit_valid (digit_valid),
    .enablen     (enablen),
    .start       (start),
    .clear       (clear),
    .done        (done),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .digit_count (digit_count),
    .locked      (locked),
    .load        (load),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit c, input bit dn, input bit st,
                       input bit dv, input bit en, input int dg);
    m_load = 0;
    m_err  = 0;
    if (r) begin
      m_time = 0; m_cnt = 0; m_lock = 0;
    end else if (c || (dn && m_lock)) begin
      m_time = 0; m_cnt = 0; m_lock = 0;
    end else if (st && !m_lock) begin
      if (m_time != 0 && ((m_time / 10) % 10) <= 5) begin
        m_lock = 1; m_load = 1;
      end else begin
        m_err = 1;
      end
    end else if (dv && !en && dg <= 9 && !m_lock && m_cnt < 4) begin
      m_time = (m_time * 10 + dg) % 10000;
      m_cnt++;
    end
  endtask

  task automatic check();
    n_vec++;
    cmp("min_tens", int'(min_tens), (m_time / 1000) % 10);
    cmp("min_ones", int'(min_ones), (m_time / 100) % 10);
    cmp("sec_tens", int'(sec_tens), (m_time / 10) % 10);
    cmp("sec_ones", int'(sec_ones), m_time % 10);
    cmp("digit_count", int'(digit_count), m_cnt);
    cmp("locked", int'(locked), int'(m_lock));
    cmp("load", int'(load), int'(m_load));
    cmp("err", int'(err), int'(m_err));
    cmp("load_err_exclusive", int'(load & err), 0);
  endtask

  task automatic step(input bit r, input bit c, input bit dn, input bit st,
                      input bit dv, input bit en, input int dg);
    @(negedge clk);
    rst = r; clear = c; done = dn; start = st;
    digit_valid = dv; enablen = en; digit = 4'(dg);
    @(posedge clk);
    model(r, c, dn, st, dv, en, dg);
    #1;
    check();
  endtask

  task automatic key(input int dg);
    step(0, 0, 0, 0, 1, 0, dg);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    cmp("lit_reset_count", int'(digit_count), 0);
    cmp("lit_reset_locked", int'(locked), 0);

    key(1); key(3); key(0);
    cmp("lit_130_mt", int'(min_tens), 0);
    cmp("lit_130_mo", int'(min_ones), 1);
    cmp("lit_130_st", int'(sec_tens), 3);
    cmp("lit_130_so", int'(sec_ones), 0);
    cmp("lit_130_cnt", int'(digit_count), 3);
    step(0, 0, 0, 1, 0, 0, 0);
    cmp("lit_130_load", int'(load), 1);
    cmp("lit_130_locked", int'(locked), 1);
    idle();
    cmp("lit_load_one_cycle", int'(load), 0);

    step(0, 1, 0, 0, 0, 0, 0);
    key(1); key(2); key(3); key(4); key(5);
    cmp("lit_full_mt", int'(min_tens), 1);
    cmp("lit_full_so", int'(sec_ones), 4);
    cmp("lit_full_cnt", int'(digit_count), 4);

    step(0, 1, 0, 0, 0, 0, 0);
    key(0); key(9); key(9);
    step(0, 0, 0, 1, 0, 0, 0);
    cmp("lit_099_err", int'(err), 1);
    cmp("lit_099_locked", int'(locked), 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    cmp("lit_empty_err", int'(err), 1);

    key(11);
    step(0, 0, 0, 0, 1, 1, 7);
    cmp("lit_dropped_cnt", int'(digit_count), 0);
    key(0); key(3); key(0);
    step(0, 0, 0, 1, 1, 0, 5);
    cmp("lit_dv_start_load", int'(load), 1);
    cmp("lit_dv_start_so", int'(sec_ones), 0);

    for (int rep = 0; rep < 2; rep++) begin
      step(0, 1, 0, 0, 0, 0, 0);
      key(1); key(3); key(0);
      step(0, 0, 0, 1, 0, 0, 0);
      key(5);
      cmp("lit_locked_digit_so", int'(sec_ones), 0);
      step(0, 0, 0, 1, 0, 0, 0);
      cmp("lit_locked_start_load", int'(load), 0);
      step(0, rep == 1, rep == 0, 0, 0, 0, 0);
      cmp("lit_release_cnt", int'(digit_count), 0);
      cmp("lit_release_mo", int'(min_ones), 0);
      cmp("lit_release_locked", int'(locked), 0);
    end

    key(2); key(7);
    step(1, 0, 0, 0, 0, 0, 0);
    cmp("lit_rst_entry_so", int'(sec_ones), 0);
    cmp("lit_rst_entry_cnt", int'(digit_count), 0);
    key(1); key(3); key(0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    cmp("lit_rst_locked", int'(locked), 0);
    cmp("lit_rst_load", int'(load), 0);

    for (int i = 0; i < 3000; i++) begin
      bit r, c, dn, st, dv, en;
      int dg;
      r  = ($urandom_range(0, 199) == 0);
      c  = ($urandom_range(0, 39) == 0);
      dn = ($urandom_range(0, 14) == 0);
      st = ($urandom_range(0, 9) == 0);
      dv = ($urandom_range(0, 1) == 1);
      en = ($urandom_range(0, 9) == 0);
      dg = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      step(r, c, dn, st, dv, en, dg);
    end

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
